// File: rtl/positron_weight_sequencer.sv
`default_nettype none
// ============================================================================
// positron_weight_sequencer : weight memory + frame sequencer feeding a positron layer
// Optional: SHORT_FRAME_ERR_EN builds the sticky short-frame error flag on err_o.
// Revision: 1.0
// ============================================================================
module positron_weight_sequencer #(
  parameter int NB_UPSTREAM_POSITRON = 784,
  parameter int NB_POSITRON          = 20,
  parameter int POSIT_WIDTH          = 16,
  parameter int WEIGHT_WIDTH         = 8,
  parameter int FRAME_CNT_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_start_i,
  input  logic                                  cfg_we_i,
  input  logic [$clog2(NB_UPSTREAM_POSITRON)-1:0] cfg_addr_i,
  input  logic [NB_POSITRON*WEIGHT_WIDTH-1:0]   cfg_data_i,
  output logic                                  loaded_o,
  output logic                                  rtr_o,
  input  logic                                  rts_i,
  input  logic                                  eow_i,
  input  logic [POSIT_WIDTH-1:0]                posit_i,
  input  logic                                  rtr_i,
  output logic                                  rts_o,
  output logic                                  sow_o,
  output logic                                  eow_o,
  output logic                                  dma_eow_o,
  output logic [POSIT_WIDTH-1:0]                posit_o,
  output logic [NB_POSITRON*WEIGHT_WIDTH-1:0]   weights_o,
  output logic [FRAME_CNT_WIDTH-1:0]            frame_cnt_o,
  output logic                                  err_o
);

  localparam int ADDR_WIDTH = $clog2(NB_UPSTREAM_POSITRON);
  localparam int ROW_WIDTH  = NB_POSITRON * WEIGHT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NB_UPSTREAM_POSITRON - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ROW_WIDTH-1:0]  mem [NB_UPSTREAM_POSITRON];
  logic [ADDR_WIDTH-1:0] wc;
  logic                  wc_last;
  logic                  accept;
  logic                  take;
  logic                  wr_en;
  logic                  wr_last;
  logic                  enter_load;

  assign wc_last = (wc == LAST_IDX);
  assign accept  = rts_i & rtr_o;
  assign take    = rts_o & rtr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rtr_o      = 1'b0;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    enter_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start_i) begin
          enter_load = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_en   = cfg_we_i && (32'(cfg_addr_i) < 32'(NB_UPSTREAM_POSITRON));
        wr_last = cfg_we_i && (cfg_addr_i == LAST_IDX);
        if (wr_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        // Reload only at a frame boundary with nothing in flight; input is blocked that cycle.
        if (cfg_start_i && (wc == '0) && !rts_o) begin
          enter_load = 1'b1;
          state_nxt  = S_LOAD;
        end else begin
          rtr_o = ~rts_o | rtr_i;
          if (rts_i && eow_i && (~rts_o | rtr_i)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!rts_o || take) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Weight rows are not reset; a reload is required after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cfg_addr_i] <= cfg_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_o <= 1'b0;
    end else if (enter_load) begin
      loaded_o <= 1'b0;
    end else if (wr_last) begin
      loaded_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc <= '0;
    end else if (accept) begin
      if (eow_i || wc_last) wc <= '0;
      else                  wc <= wc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_o <= '0;
    end else if (enter_load) begin
      frame_cnt_o <= '0;
    end else if (accept && wc_last) begin
      frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_o     <= 1'b0;
      sow_o     <= 1'b0;
      eow_o     <= 1'b0;
      dma_eow_o <= 1'b0;
      posit_o   <= '0;
      weights_o <= '0;
    end else if (accept) begin
      rts_o     <= 1'b1;
      sow_o     <= (wc == '0);
      eow_o     <= wc_last;
      dma_eow_o <= eow_i;
      posit_o   <= posit_i;
      weights_o <= mem[wc];
    end else if (take) begin
      rts_o <= 1'b0;
    end
  end

`ifdef SHORT_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (enter_load) begin
      err_o <= 1'b0;
    end else if (accept && eow_i && !wc_last) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire
